// File: rtl/writeback_stage.sv
// Writeback stage: picks the result source (ALU, memory load, link address
// or CSR), sign/zero-extends load data, waits for the memory response when
// needed, and issues one register-file write per retired request.
module writeback_stage #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic              in_wen,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_csr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  localparam logic [1:0]      SEL_MEM  = 2'd1;
  localparam logic [1:0]      SEL_LINK = 2'd2;
  localparam logic [1:0]      SEL_CSR  = 2'd3;
  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

  state_t            r_state;
  state_t            w_state_next;

  // Request fields held while a load waits for its memory response.
  logic              r_ld_wen;
  logic [RA_W-1:0]   r_ld_rd;
  logic [1:0]        r_ld_size;
  logic              r_ld_unsigned;

  // Registered write port and retire counter.
  logic              r_we;
  logic [RA_W-1:0]   r_waddr;
  logic [XLEN-1:0]   r_wdata;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_hs;
  logic              w_hs_mem;
  logic              w_hs_direct;
  logic              w_mem_done;
  logic [XLEN-1:0]   w_src;
  logic [XLEN-1:0]   w_ext;

  // Only WAIT_MEM blocks new requests, so ready depends on the state alone.
  assign in_ready    = (r_state != S_WAIT_MEM);
  assign busy        = (r_state != S_IDLE);
  assign w_hs        = in_valid & in_ready;
  assign w_hs_mem    = w_hs & (in_sel == SEL_MEM);
  assign w_hs_direct = w_hs & (in_sel != SEL_MEM);
  // The response is only looked at while a load is outstanding.
  assign w_mem_done  = (r_state == S_WAIT_MEM) & mem_rsp_valid;

  assign rf_we       = r_we;
  assign rf_waddr    = r_waddr;
  assign rf_wdata    = r_wdata;
  assign retire_cnt  = r_retire_cnt;

  // Next-state decode: IDLE and WRITE both accept requests.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (w_hs_mem)         w_state_next = S_WAIT_MEM;
        else if (w_hs_direct) w_state_next = S_WRITE;
        else                  w_state_next = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (mem_rsp_valid)    w_state_next = S_WRITE;
      end
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Result mux for sources that are available at handshake time.
  always_comb begin
    w_src = in_alu;
    case (in_sel)
      SEL_LINK: w_src = in_pc + LINK_OFS;
      SEL_CSR:  w_src = in_csr;
      default:  w_src = in_alu;
    endcase
  end

  // Load extension; on a 32-bit datapath word and double both take the full word.
  generate
    if (XLEN == 64) begin : g_ext64
      always_comb begin
        w_ext = mem_rsp_data;
        case (r_ld_size)
          2'd0: w_ext = r_ld_unsigned ? {{56{1'b0}}, mem_rsp_data[7:0]}
                                      : {{56{mem_rsp_data[7]}}, mem_rsp_data[7:0]};
          2'd1: w_ext = r_ld_unsigned ? {{48{1'b0}}, mem_rsp_data[15:0]}
                                      : {{48{mem_rsp_data[15]}}, mem_rsp_data[15:0]};
          2'd2: w_ext = r_ld_unsigned ? {{32{1'b0}}, mem_rsp_data[31:0]}
                                      : {{32{mem_rsp_data[31]}}, mem_rsp_data[31:0]};
          default: w_ext = mem_rsp_data;
        endcase
      end
    end else begin : g_ext32
      always_comb begin
        w_ext = mem_rsp_data;
        case (r_ld_size)
          2'd0: w_ext = r_ld_unsigned ? {{24{1'b0}}, mem_rsp_data[7:0]}
                                      : {{24{mem_rsp_data[7]}}, mem_rsp_data[7:0]};
          2'd1: w_ext = r_ld_unsigned ? {{16{1'b0}}, mem_rsp_data[15:0]}
                                      : {{16{mem_rsp_data[15]}}, mem_rsp_data[15:0]};
          default: w_ext = mem_rsp_data;
        endcase
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Capture the request fields a load needs once its data returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_wen      <= 1'b0;
      r_ld_rd       <= '0;
      r_ld_size     <= 2'd0;
      r_ld_unsigned <= 1'b0;
    end else if (w_hs_mem) begin
      r_ld_wen      <= in_wen;
      r_ld_rd       <= in_rd;
      r_ld_size     <= in_size;
      r_ld_unsigned <= in_unsigned;
    end
  end

  // Write port: loaded on every entry into WRITE, address/data hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_hs_direct) begin
      r_we    <= in_wen && (in_rd != '0);
      r_waddr <= in_rd;
      r_wdata <= w_src;
    end else if (w_mem_done) begin
      r_we    <= r_ld_wen && (r_ld_rd != '0);
      r_waddr <= r_ld_rd;
      r_wdata <= w_ext;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Retire count steps on entry to WRITE, so it already includes the
  // request being written while rf_we is high; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_retire_cnt <= '0;
    else if (w_state_next == S_WRITE) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (XLEN 64, RA_W 5, CNT_W 64).
module tb_writeback_stage;

  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int CNT_W = 64;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic              in_wen;
  logic [RA_W-1:0]   in_rd;
  logic [XLEN-1:0]   in_alu;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_csr;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              busy;
  logic [CNT_W-1:0]  retire_cnt;

  int n_cmp;
  int n_err;
  logic [CNT_W-1:0] exp_cnt;

  writeback_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .in_wen        (in_wen),
    .in_rd         (in_rd),
    .in_alu        (in_alu),
    .in_pc         (in_pc),
    .in_csr        (in_csr),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy          (busy),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_wen = 1'b0; in_rd = '0;
    in_alu = '0; in_pc = '0; in_csr = '0; in_size = 2'd0; in_unsigned = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    exp_cnt = '0;
    #3;
    n_cmp++; if (rf_we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %0b want 0", rf_we); end
    n_cmp++; if (rf_waddr !== '0)    begin n_err++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== '0)    begin n_err++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (retire_cnt !== '0)  begin n_err++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    step; step;
    reset_n = 1'b1;
    step;
    $display("reset released, outputs idle");
  endtask

  task automatic test_alu;
    in_valid = 1'b1; in_sel = 2'd0; in_alu = 64'h1234; in_rd = 5'd5; in_wen = 1'b1;
    step;
    exp_cnt = exp_cnt + 1;
    in_valid = 1'b0;
    $display("alu write rd=%0d data=%h cnt=%0d", rf_waddr, rf_wdata, retire_cnt);
    n_cmp++; if (rf_we !== 1'b1)        begin n_err++; $display("FAIL alu_we: got %0b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd5)     begin n_err++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'h1234) begin n_err++; $display("FAIL alu_wdata: got %h want 1234", rf_wdata); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_err++; $display("FAIL alu_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL alu_busy: got %0b want 1", busy); end
    step;
    n_cmp++; if (rf_we !== 1'b0)        begin n_err++; $display("FAIL alu_we_after: got %0b want 0", rf_we); end
    n_cmp++; if (rf_wdata !== 64'h1234) begin n_err++; $display("FAIL alu_wdata_hold: got %h want 1234", rf_wdata); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL alu_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_link_csr;
    // LINK with rd 0: wraps to 0, no write, still retires.
    in_valid = 1'b1; in_sel = 2'd2; in_pc = 64'hFFFF_FFFF_FFFF_FFFC; in_rd = 5'd0; in_wen = 1'b1;
    step;
    exp_cnt = exp_cnt + 1;
    $display("link rd=%0d data=%h we=%0b cnt=%0d", rf_waddr, rf_wdata, rf_we, retire_cnt);
    n_cmp++; if (rf_we !== 1'b0)         begin n_err++; $display("FAIL link_we_rd0: got %0b want 0", rf_we); end
    n_cmp++; if (rf_wdata !== 64'h0)     begin n_err++; $display("FAIL link_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_err++; $display("FAIL link_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    // CSR with wen 0: no write, data still presented.
    in_sel = 2'd3; in_csr = 64'hDEAD_BEEF_0000_0011; in_rd = 5'd9; in_wen = 1'b0;
    step;
    exp_cnt = exp_cnt + 1;
    in_valid = 1'b0;
    $display("csr rd=%0d data=%h we=%0b cnt=%0d", rf_waddr, rf_wdata, rf_we, retire_cnt);
    n_cmp++; if (rf_we !== 1'b0)                   begin n_err++; $display("FAIL csr_we_wen0: got %0b want 0", rf_we); end
    n_cmp++; if (rf_wdata !== 64'hDEAD_BEEF_0000_0011) begin n_err++; $display("FAIL csr_wdata: got %h want deadbeef00000011", rf_wdata); end
    n_cmp++; if (rf_waddr !== 5'd9)                begin n_err++; $display("FAIL csr_waddr: got %0d want 9", rf_waddr); end
    n_cmp++; if (retire_cnt !== exp_cnt)           begin n_err++; $display("FAIL csr_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    step;
  endtask

  // One load: handshake, 3 wait cycles, response, then check the written value.
  task automatic do_load(input logic [1:0] size, input logic uns, input logic [XLEN-1:0] data,
                         input logic [XLEN-1:0] expect_data, input logic [RA_W-1:0] rd);
    logic [XLEN-1:0] prev_data;
    prev_data = rf_wdata;
    in_valid = 1'b1; in_sel = 2'd1; in_size = size; in_unsigned = uns; in_rd = rd; in_wen = 1'b1;
    in_alu = 64'h5555; mem_rsp_data = data;
    step;
    in_valid = 1'b0; in_unsigned = ~uns; in_size = ~size;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_wait%0d: got %0b want 0", i, in_ready); end
      n_cmp++; if (rf_we !== 1'b0)    begin n_err++; $display("FAIL load_we_wait%0d: got %0b want 0", i, rf_we); end
      n_cmp++; if (rf_wdata !== prev_data) begin n_err++; $display("FAIL load_wdata_hold%0d: got %h want %h", i, rf_wdata, prev_data); end
      if (i == 2) mem_rsp_valid = 1'b1;
      step;
    end
    mem_rsp_valid = 1'b0;
    exp_cnt = exp_cnt + 1;
    $display("load size=%0d uns=%0b rd=%0d data=%h cnt=%0d", size, uns, rf_waddr, rf_wdata, retire_cnt);
    n_cmp++; if (rf_we !== 1'b1)          begin n_err++; $display("FAIL load_we: got %0b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== rd)         begin n_err++; $display("FAIL load_waddr: got %0d want %0d", rf_waddr, rd); end
    n_cmp++; if (rf_wdata !== expect_data) begin n_err++; $display("FAIL load_wdata: got %h want %h", rf_wdata, expect_data); end
    n_cmp++; if (retire_cnt !== exp_cnt)  begin n_err++; $display("FAIL load_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    n_cmp++; if (in_ready !== 1'b1)       begin n_err++; $display("FAIL load_ready_write: got %0b want 1", in_ready); end
    step;
  endtask

  task automatic test_loads;
    do_load(2'd0, 1'b0, 64'h80,                  64'hFFFF_FFFF_FFFF_FF80, 5'd7);
    do_load(2'd0, 1'b1, 64'h80,                  64'h80,                  5'd7);
    do_load(2'd1, 1'b0, 64'h1234_5678_1234_8001, 64'hFFFF_FFFF_FFFF_8001, 5'd8);
    do_load(2'd2, 1'b1, 64'hFFFF_0000_9000_0002, 64'h0000_0000_9000_0002, 5'd10);
    do_load(2'd3, 1'b0, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9, 5'd31);
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; in_sel = 2'd0; in_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %0b want 1", i, in_ready); end
      in_alu = 64'hA000 + 64'(i); in_rd = 5'(i + 1);
      step;
      exp_cnt = exp_cnt + 1;
      $display("b2b write rd=%0d data=%h cnt=%0d", rf_waddr, rf_wdata, retire_cnt);
      n_cmp++; if (rf_we !== 1'b1)             begin n_err++; $display("FAIL b2b_we%0d: got %0b want 1", i, rf_we); end
      n_cmp++; if (rf_waddr !== 5'(i + 1))     begin n_err++; $display("FAIL b2b_waddr%0d: got %0d want %0d", i, rf_waddr, i + 1); end
      n_cmp++; if (rf_wdata !== 64'hA000 + 64'(i)) begin n_err++; $display("FAIL b2b_wdata%0d: got %h want %h", i, rf_wdata, 64'hA000 + 64'(i)); end
      n_cmp++; if (retire_cnt !== exp_cnt)     begin n_err++; $display("FAIL b2b_cnt%0d: got %0d want %0d", i, retire_cnt, exp_cnt); end
    end
    in_valid = 1'b0;
    step;
    n_cmp++; if (rf_we !== 1'b0)         begin n_err++; $display("FAIL b2b_we_end: got %0b want 0", rf_we); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt_end: got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_stray_rsp;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h77;
    step; step;
    $display("stray response in idle: we=%0b busy=%0b cnt=%0d", rf_we, busy, retire_cnt);
    n_cmp++; if (rf_we !== 1'b0)         begin n_err++; $display("FAIL stray_we: got %0b want 0", rf_we); end
    n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL stray_busy: got %0b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1)      begin n_err++; $display("FAIL stray_ready: got %0b want 1", in_ready); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_err++; $display("FAIL stray_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    // Response present in the load's own handshake cycle must not complete it.
    in_valid = 1'b1; in_sel = 2'd1; in_size = 2'd0; in_unsigned = 1'b1; in_rd = 5'd3; in_wen = 1'b1;
    step;
    in_valid = 1'b0; mem_rsp_valid = 1'b0;
    n_cmp++; if (rf_we !== 1'b0)    begin n_err++; $display("FAIL hs_rsp_we: got %0b want 0", rf_we); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hs_rsp_ready: got %0b want 0", in_ready); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1FF;
    step;
    mem_rsp_valid = 1'b0;
    exp_cnt = exp_cnt + 1;
    $display("load after ignored response rd=%0d data=%h", rf_waddr, rf_wdata);
    n_cmp++; if (rf_we !== 1'b1)        begin n_err++; $display("FAIL hs_rsp_load_we: got %0b want 1", rf_we); end
    n_cmp++; if (rf_wdata !== 64'hFF)   begin n_err++; $display("FAIL hs_rsp_load_wdata: got %h want ff", rf_wdata); end
    step;
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_sel = 2'd1; in_size = 2'd3; in_rd = 5'd12; in_wen = 1'b1;
    step;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_wait: got %0b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    exp_cnt = '0;
    $display("reset asserted mid wait: we=%0b data=%h cnt=%0d", rf_we, rf_wdata, retire_cnt);
    n_cmp++; if (rf_wdata !== '0)   begin n_err++; $display("FAIL rmid_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (rf_waddr !== '0)   begin n_err++; $display("FAIL rmid_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (retire_cnt !== '0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", retire_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %0b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h42;
    step;
    reset_n = 1'b1;
    step;
    mem_rsp_valid = 1'b0;
    n_cmp++; if (rf_we !== 1'b0)    begin n_err++; $display("FAIL rmid_no_write: got %0b want 0", rf_we); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rmid_state_idle: got %0b want 0", busy); end
    n_cmp++; if (retire_cnt !== '0) begin n_err++; $display("FAIL rmid_no_retire: got %0d want 0", retire_cnt); end
    // First request after reset is accepted on the next edge.
    in_valid = 1'b1; in_sel = 2'd0; in_alu = 64'hBEEF; in_rd = 5'd2; in_wen = 1'b1;
    step;
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 1;
    $display("post-reset alu rd=%0d data=%h cnt=%0d", rf_waddr, rf_wdata, retire_cnt);
    n_cmp++; if (rf_we !== 1'b1)         begin n_err++; $display("FAIL post_reset_we: got %0b want 1", rf_we); end
    n_cmp++; if (rf_wdata !== 64'hBEEF)  begin n_err++; $display("FAIL post_reset_wdata: got %h want beef", rf_wdata); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_err++; $display("FAIL post_reset_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    step;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_alu;
    test_link_csr;
    test_loads;
    test_back_to_back;
    test_stray_rsp;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
